// File: rtl/clk_freq_monitor_pkg.sv
// Shared types and default parameters for the multi-channel clock-frequency monitor.
package clk_freq_monitor_pkg;

    localparam int DEF_NUM_CH      = 4;
    localparam int DEF_CNT_W       = 16;
    localparam int DEF_WIN_W       = 16;
    localparam int DEF_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_COUNT = 2'd2,
        ST_LATCH = 2'd3
    } state_t;

endpackage

// File: rtl/clk_freq_monitor_if.sv
// Control/result bundle of clk_freq_monitor; master drives the controls, slave is the monitor.
interface clk_freq_monitor_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16,
    parameter int WIN_W  = 16
) ();
    logic                    start;
    logic                    stop;
    logic                    continuous;
    logic [WIN_W-1:0]        window;
    logic [NUM_CH*CNT_W-1:0] exp_min;
    logic [NUM_CH*CNT_W-1:0] exp_max;
    logic                    busy;
    logic                    done;
    logic [NUM_CH*CNT_W-1:0] count_o;
    logic [NUM_CH-1:0]       pass;
    logic [NUM_CH-1:0]       sat;

    modport master (
        output start, stop, continuous, window, exp_min, exp_max,
        input  busy, done, count_o, pass, sat
    );

    modport slave (
        input  start, stop, continuous, window, exp_min, exp_max,
        output busy, done, count_o, pass, sat
    );
endinterface

// File: rtl/clk_freq_monitor_edge_sync.sv
// One monitored clock brought into the wb_clk_i domain and reduced to a rising-edge pulse.
// SYNC_STAGES must be at least 2.
module clk_mon_edge_sync
    import clk_freq_monitor_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic async_in,
    output logic edge_pulse
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;
endmodule

// File: rtl/clk_freq_monitor.sv
// Multi-channel clock-frequency monitor: gated edge counting, min/max check, one-shot or continuous.
// Optional sticky failure interrupt (irq/irq_clr) when CLK_FREQ_MONITOR_IRQ_EN is defined.
module clk_freq_monitor
    import clk_freq_monitor_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int WIN_W       = DEF_WIN_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [NUM_CH-1:0] mon_clk,
`ifdef CLK_FREQ_MONITOR_IRQ_EN
    input  logic              irq_clr,
    output logic              irq,
`endif
    clk_freq_monitor_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t                  state;
    logic [WIN_W-1:0]        win_q;
    logic [WIN_W-1:0]        win_cnt;
    logic                    cont_q;
    logic                    stop_seen;
    logic [NUM_CH*CNT_W-1:0] min_q;
    logic [NUM_CH*CNT_W-1:0] max_q;
    logic [CNT_W-1:0]        cnt [NUM_CH];
    logic [NUM_CH-1:0]       live_sat;
    logic [NUM_CH-1:0]       edge_pulse;
    logic [NUM_CH-1:0]       pass_next;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_sync
        clk_mon_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .wb_clk_i   (wb_clk_i),
            .wb_rst_i   (wb_rst_i),
            .async_in   (mon_clk[g]),
            .edge_pulse (edge_pulse[g])
        );
    end

    // Inverted bounds (min > max) can never satisfy both compares, so they fail naturally.
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        pass_next = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pass_next[i] = (cnt[i] >= min_q[i*CNT_W +: CNT_W]) &&
                           (cnt[i] <= max_q[i*CNT_W +: CNT_W]);
        end
    end

    assign bus.busy = (state != ST_IDLE);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state       <= ST_IDLE;
            win_q       <= '0;
            win_cnt     <= '0;
            cont_q      <= 1'b0;
            stop_seen   <= 1'b0;
            min_q       <= '0;
            max_q       <= '0;
            live_sat    <= '0;
            bus.done    <= 1'b0;
            bus.count_o <= '0;
            bus.pass    <= '0;
            bus.sat     <= '0;
            // NOTE: the counter array is a handful of flops, not a RAM, so it is reset like any register.
            for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
        end else begin
            bus.done <= 1'b0;
            if (state != ST_IDLE && bus.stop) stop_seen <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        win_q  <= bus.window;
                        cont_q <= bus.continuous;
                        min_q  <= bus.exp_min;
                        max_q  <= bus.exp_max;
                        state  <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    win_cnt  <= win_q;
                    live_sat <= '0;
                    for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
                    state <= (win_q == '0) ? ST_LATCH : ST_COUNT;
                end
                ST_COUNT: begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (edge_pulse[i]) begin
                            if (cnt[i] == CNT_MAX) live_sat[i] <= 1'b1;
                            else                   cnt[i] <= cnt[i] + CNT_W'(1);
                        end
                    end
                    if (win_cnt == WIN_W'(1)) state   <= ST_LATCH;
                    else                      win_cnt <= win_cnt - WIN_W'(1);
                end
                ST_LATCH: begin
                    for (int i = 0; i < NUM_CH; i++) bus.count_o[i*CNT_W +: CNT_W] <= cnt[i];
                    bus.pass <= pass_next;
                    bus.sat  <= live_sat;
                    bus.done <= 1'b1;
                    // A stop arriving in this very cycle still ends the run.
                    if (cont_q && !stop_seen && !bus.stop) begin
                        state <= ST_ARM;
                    end else begin
                        state     <= ST_IDLE;
                        stop_seen <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef CLK_FREQ_MONITOR_IRQ_EN
    // Sticky failure flag; a failing LATCH outranks a simultaneous clear.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)                                                irq <= 1'b0;
        else if (state == ST_LATCH && ((~pass_next != '0) || (live_sat != '0))) irq <= 1'b1;
        else if (irq_clr)                                            irq <= 1'b0;
    end
`endif
endmodule

// File: tb/tb_clk_freq_monitor.sv
// Directed self-checking bench for clk_freq_monitor: one-shot, saturation, continuous, window=0,
// mid-window reset and (with CLK_FREQ_MONITOR_IRQ_EN) the sticky interrupt.
module tb_clk_freq_monitor;
    logic       wb_clk_i = 1'b0;
    logic       wb_rst_i = 1'b1;
    logic       m0 = 1'b0, m1 = 1'b0, m2 = 1'b0;
    logic [3:0] mon_clk;
    int         errors = 0;
    int         checks = 0;
`ifdef CLK_FREQ_MONITOR_IRQ_EN
    logic       irq_clr = 1'b0;
    logic       irq;
    logic       irq_sat;
`endif

    assign mon_clk = {1'b0, m2, m1, m0};

    clk_freq_monitor_if #(.NUM_CH(4), .CNT_W(16), .WIN_W(16)) dbus ();
    clk_freq_monitor_if #(.NUM_CH(4), .CNT_W(8),  .WIN_W(16)) sbus ();

    clk_freq_monitor #(.NUM_CH(4), .CNT_W(16), .WIN_W(16), .SYNC_STAGES(2)) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .mon_clk  (mon_clk),
`ifdef CLK_FREQ_MONITOR_IRQ_EN
        .irq_clr  (irq_clr),
        .irq      (irq),
`endif
        .bus      (dbus)
    );

    clk_freq_monitor #(.NUM_CH(4), .CNT_W(8), .WIN_W(16), .SYNC_STAGES(2)) dut_sat (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .mon_clk  (mon_clk),
`ifdef CLK_FREQ_MONITOR_IRQ_EN
        .irq_clr  (1'b0),
        .irq      (irq_sat),
`endif
        .bus      (sbus)
    );

    always #5 wb_clk_i = ~wb_clk_i;
    initial begin #3; forever #20 m0 = ~m0; end
    initial begin #3; forever #60 m1 = ~m1; end
    initial begin #3; forever #10 m2 = ~m2; end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    task automatic set_cfg(input logic [15:0] win, input logic cont,
                           input logic [63:0] lo, input logic [63:0] hi);
        dbus.window = win; dbus.continuous = cont; dbus.exp_min = lo; dbus.exp_max = hi;
    endtask

    task automatic pulse_start(input logic on_sat);
        @(negedge wb_clk_i);
        if (on_sat) sbus.start = 1'b1; else dbus.start = 1'b1;
        @(negedge wb_clk_i);
        sbus.start = 1'b0; dbus.start = 1'b0;
    endtask

    // Counts cycles until done; optionally pulses start/stop on dbus at cycle poke_at.
    task automatic wait_done(input logic on_sat, input int limit, input int poke_at,
                             input logic poke_start, input logic poke_stop, output int n);
        logic seen;
        n = 0; seen = 1'b0;
        while (!seen && n < limit) begin
            @(negedge wb_clk_i);
            n++;
            dbus.start = (n == poke_at) && poke_start;
            dbus.stop  = (n == poke_at) && poke_stop;
            seen = on_sat ? sbus.done : dbus.done;
        end
        dbus.start = 1'b0; dbus.stop = 1'b0;
        if (!seen) begin
            checks++; errors++;
            $display("FAIL done_timeout: no done within %0d cycles", limit);
        end
    endtask

    task automatic test_reset();
        dbus.start = 0; dbus.stop = 0; sbus.start = 0; sbus.stop = 0;
        set_cfg(16'd0, 1'b0, '0, '0);
        sbus.window = '0; sbus.continuous = 0; sbus.exp_min = '0; sbus.exp_max = '0;
        wb_rst_i = 1'b1;
        repeat (3) @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        checks++; if (dbus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", dbus.busy); end
        checks++; if (dbus.done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", dbus.done); end
        checks++; if (dbus.count_o !== 64'd0) begin errors++; $display("FAIL rst_count: got %h want 0", dbus.count_o); end
        checks++; if (dbus.pass !== 4'd0) begin errors++; $display("FAIL rst_pass: got %b want 0", dbus.pass); end
        checks++; if (dbus.sat !== 4'd0) begin errors++; $display("FAIL rst_sat: got %b want 0", dbus.sat); end
    endtask

    task automatic check_nominal(input string tag);
        int c;
        c = int'(dbus.count_o[15:0]);
        checks++; if (c < 249 || c > 251) begin errors++; $display("FAIL %s_ch0: got %0d want 249..251", tag, c); end
        c = int'(dbus.count_o[31:16]);
        checks++; if (c < 82 || c > 84) begin errors++; $display("FAIL %s_ch1: got %0d want 82..84", tag, c); end
        c = int'(dbus.count_o[47:32]);
        checks++; if (c < 499 || c > 501) begin errors++; $display("FAIL %s_ch2: got %0d want 499..501", tag, c); end
        c = int'(dbus.count_o[63:48]);
        checks++; if (c != 0) begin errors++; $display("FAIL %s_ch3: got %0d want 0", tag, c); end
        checks++; if (dbus.pass !== 4'b0111) begin errors++; $display("FAIL %s_pass: got %b want 0111", tag, dbus.pass); end
        checks++; if (dbus.sat !== 4'b0000) begin errors++; $display("FAIL %s_sat: got %b want 0000", tag, dbus.sat); end
    endtask

    task automatic test_oneshot();
        int n;
        set_cfg(16'd1000, 1'b0, {16'd1, 16'd499, 16'd82, 16'd249}, {16'hFFFF, 16'd501, 16'd84, 16'd251});
        pulse_start(1'b0);
        wait_done(1'b0, 1100, 0, 1'b0, 1'b0, n);
        checks++; if (n != 1002) begin errors++; $display("FAIL oneshot_latency: got %0d want 1002", n); end
        check_nominal("oneshot");
        checks++; if (dbus.busy !== 1'b0) begin errors++; $display("FAIL oneshot_busy: got %b want 0", dbus.busy); end
        @(negedge wb_clk_i);
        checks++; if (dbus.done !== 1'b0) begin errors++; $display("FAIL oneshot_done_width: got %b want 0", dbus.done); end
    endtask

    task automatic test_saturation();
        int n;
        sbus.window = 16'd1000; sbus.continuous = 1'b0;
        sbus.exp_min = {8'd0, 8'd100, 8'd0, 8'd0};
        sbus.exp_max = {8'd255, 8'd200, 8'd255, 8'd255};
        pulse_start(1'b1);
        wait_done(1'b1, 1100, 0, 1'b0, 1'b0, n);
        checks++; if (n != 1002) begin errors++; $display("FAIL sat_latency: got %0d want 1002", n); end
        checks++; if (sbus.count_o[23:16] !== 8'd255) begin errors++; $display("FAIL sat_ch2_count: got %0d want 255", sbus.count_o[23:16]); end
        checks++; if (sbus.sat !== 4'b0100) begin errors++; $display("FAIL sat_bits: got %b want 0100", sbus.sat); end
        checks++; if (sbus.pass !== 4'b1011) begin errors++; $display("FAIL sat_pass: got %b want 1011", sbus.pass); end
    endtask

    task automatic test_window_zero();
        int n;
        set_cfg(16'd0, 1'b0, 64'd0, 64'd0);
        pulse_start(1'b0);
        wait_done(1'b0, 20, 0, 1'b0, 1'b0, n);
        checks++; if (n != 2) begin errors++; $display("FAIL win0_latency: got %0d want 2", n); end
        checks++; if (dbus.count_o !== 64'd0) begin errors++; $display("FAIL win0_count: got %h want 0", dbus.count_o); end
        checks++; if (dbus.pass !== 4'b1111) begin errors++; $display("FAIL win0_pass: got %b want 1111", dbus.pass); end
        checks++; if (dbus.sat !== 4'b0000) begin errors++; $display("FAIL win0_sat: got %b want 0000", dbus.sat); end
    endtask

    task automatic test_continuous();
        int n, c, extra;
        set_cfg(16'd100, 1'b1, 64'd0, {4{16'hFFFF}});
        pulse_start(1'b0);
        wait_done(1'b0, 200, 0, 1'b0, 1'b0, n);
        checks++; if (n != 102) begin errors++; $display("FAIL cont_first: got %0d want 102", n); end
        c = int'(dbus.count_o[15:0]);
        checks++; if (c < 24 || c > 26) begin errors++; $display("FAIL cont_ch0: got %0d want 24..26", c); end
        // start while busy must not disturb the period
        wait_done(1'b0, 200, 30, 1'b1, 1'b0, n);
        checks++; if (n != 102) begin errors++; $display("FAIL cont_period_start_busy: got %0d want 102", n); end
        checks++; if (dbus.busy !== 1'b1) begin errors++; $display("FAIL cont_busy: got %b want 1", dbus.busy); end
        wait_done(1'b0, 200, 50, 1'b0, 1'b1, n);
        checks++; if (n != 102) begin errors++; $display("FAIL cont_stop_last: got %0d want 102", n); end
        checks++; if (dbus.busy !== 1'b0) begin errors++; $display("FAIL cont_stop_busy: got %b want 0", dbus.busy); end
        extra = 0;
        repeat (250) begin @(negedge wb_clk_i); if (dbus.done) extra++; end
        checks++; if (extra != 0) begin errors++; $display("FAIL cont_after_stop: got %0d dones want 0", extra); end
    endtask

    task automatic test_reset_mid_window();
        int n, extra;
        set_cfg(16'd1000, 1'b0, {16'd1, 16'd499, 16'd82, 16'd249}, {16'hFFFF, 16'd501, 16'd84, 16'd251});
        pulse_start(1'b0);
        extra = 0;
        repeat (500) begin @(negedge wb_clk_i); if (dbus.done) extra++; end
        checks++; if (dbus.busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_before: got %b want 1", dbus.busy); end
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        checks++; if (dbus.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", dbus.busy); end
        checks++; if (dbus.count_o !== 64'd0) begin errors++; $display("FAIL rmid_count: got %h want 0", dbus.count_o); end
        repeat (600) begin @(negedge wb_clk_i); if (dbus.done) extra++; end
        checks++; if (extra != 0) begin errors++; $display("FAIL rmid_no_done: got %0d dones want 0", extra); end
        pulse_start(1'b0);
        wait_done(1'b0, 1100, 0, 1'b0, 1'b0, n);
        checks++; if (n != 1002) begin errors++; $display("FAIL rmid_restart_latency: got %0d want 1002", n); end
        check_nominal("rmid_restart");
    endtask

`ifdef CLK_FREQ_MONITOR_IRQ_EN
    task automatic test_irq();
        int n;
        @(negedge wb_clk_i); irq_clr = 1'b1;
        @(negedge wb_clk_i); irq_clr = 1'b0;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_cleared: got %b want 0", irq); end
        set_cfg(16'd100, 1'b0, {16'd1, 48'd0}, {4{16'hFFFF}});
        pulse_start(1'b0);
        wait_done(1'b0, 200, 0, 1'b0, 1'b0, n);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set: got %b want 1", irq); end
        repeat (20) @(negedge wb_clk_i);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold: got %b want 1", irq); end
        irq_clr = 1'b1;
        @(negedge wb_clk_i);
        irq_clr = 1'b0;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clr: got %b want 0", irq); end
        irq_clr = 1'b1;
        pulse_start(1'b0);
        wait_done(1'b0, 200, 0, 1'b0, 1'b0, n);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set_wins: got %b want 1", irq); end
        @(negedge wb_clk_i);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clr_after: got %b want 0", irq); end
        irq_clr = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_oneshot();
        test_saturation();
        test_window_zero();
        test_continuous();
        test_reset_mid_window();
`ifdef CLK_FREQ_MONITOR_IRQ_EN
        test_irq();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/clk_freq_monitor.md
Name: clk_freq_monitor

Overview:
- Synthesizable multi-channel clock-frequency monitor for the management SoC.
- Counts rising edges of NUM_CH asynchronous monitored clocks (user clock, core clock, PLL outputs) over a programmable gate window measured in wb_clk_i cycles.
- Latches per-channel counts and checks each against a min/max window.
- Supports one-shot and continuous modes, so PLL/divider checks run in silicon rather than only in a bench.

Parameters:
- NUM_CH, 4, number of monitored clock channels
- CNT_W, 16, per-channel edge-counter width (saturating)
- WIN_W, 16, gate-window counter width
- SYNC_STAGES, 2, synchronizer depth per channel (minimum 2)

Ports:
- wb_clk_i  in  1  system clock; all logic in this domain
- wb_rst_i  in  1  synchronous active-high reset
- mon_clk  in  NUM_CH  monitored clocks, asynchronous; must be below wb_clk_i/2
- start  in  1  begin measurement; sampled only in IDLE
- stop  in  1  continuous mode: finish the current window, then go IDLE
- continuous  in  1  0 = one-shot, 1 = repeat windows back-to-back; sampled with start
- window  in  WIN_W  gate length in wb_clk_i cycles; sampled with start
- exp_min  in  NUM_CH*CNT_W  per-channel lower bound (inclusive), channel i at [i*CNT_W +: CNT_W]
- exp_max  in  NUM_CH*CNT_W  per-channel upper bound (inclusive)
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when results update
- count_o  out  NUM_CH*CNT_W  latched edge counts
- pass  out  NUM_CH  count_o[i] within [exp_min[i], exp_max[i]]
- sat  out  NUM_CH  channel counter saturated during the last window

Behaviour:
- Reset: state=IDLE; busy=0, done=0, count_o=0, pass=0, sat=0; synchronizer and edge-detect flops cleared; live counters cleared.
- Per channel: SYNC_STAGES-flop synchronizer feeds a previous-value flop. An edge is (sync & ~prev).
- FSM states are IDLE, ARM, COUNT, LATCH.
- IDLE -> ARM when start=1. Latch window, continuous, exp_min and exp_max.
- ARM, one cycle: clear live counters, load the window down-counter. Edges seen in ARM are not counted.
- COUNT: runs for exactly the latched window cycles. Each edge increments its channel counter; the counter saturates at all-ones and sets the live sat bit.
- COUNT -> LATCH once the down-counter reaches 1.
- LATCH, one cycle:
  - Copy counters to count_o; compute pass and sat; done=1.
  - If continuous=1 and stop has not been seen: -> ARM. Otherwise -> IDLE.
- Timing: start accepted in cycle t gives done in cycle t+window+2. Outputs are valid from that cycle until the next LATCH.
- window=0: COUNT is skipped (ARM -> LATCH). Counts are 0; pass reflects 0 against the bounds.
- stop is sticky once seen in ARM, COUNT or LATCH. It is cleared on entry to IDLE and ignored in one-shot mode.
- start while busy: ignored.
- start and stop high together in IDLE: start is accepted and stop is ignored.
- Reset mid-window: immediate return to the reset state. Partial counts are discarded; no done pulse.
- Bounds with exp_min > exp_max: pass=0.

Optional Feature:
- Macro: CLK_FREQ_MONITOR_IRQ_EN.
- With the macro: adds ports irq (out, 1) and irq_clr (in, 1).
  - irq is a sticky flop set in any LATCH where any pass bit is 0 or any sat bit is 1.
  - irq_clr clears it. Set wins over a simultaneous clear. Reset value 0.
- Without the macro: neither port exists and no irq logic is present.

Decomposition:
- Package clk_freq_monitor_pkg holds:
  - state enum (IDLE, ARM, COUNT, LATCH) with 2-bit encoding
  - default parameter constants (NUM_CH, CNT_W, WIN_W, SYNC_STAGES)
- Sub-module clk_mon_edge_sync, instantiated NUM_CH times: SYNC_STAGES synchronizer plus rising-edge detector, one bit in and one edge pulse out, reset by wb_rst_i.

Test Plan:
- Bench setup: wb_clk_i = 10 ns. Channel clocks are ch0 = 40 ns, ch1 = 120 ns, ch2 = 20 ns, ch3 tied 0.
- One-shot, window=1000: count_o ch0 in 249..251, ch1 in 82..84, ch2 in 499..501, ch3 = 0.
  - With bounds [249,251], [82,84], [499,501], [1,65535]: pass=4'b0111.
  - done pulses exactly 1002 cycles after start.
- Saturation (CNT_W=8): ch2 at 20 ns, window=1000 -> count_o ch2=255, sat[2]=1, pass[2]=0.
- Continuous, window=100: done pulses every 102 cycles.
  - stop asserted mid-window -> exactly one more done, then busy=0.
  - start pulsed while busy has no effect.
- window=0: done at start+2, all counts 0; exp_min=0, exp_max=0 -> pass=all 1.
- Reset at cycle 500 of a 1000-cycle window:
  - busy=0 next cycle, count_o=0, no done.
  - A fresh start then produces normal results.
- With CLK_FREQ_MONITOR_IRQ_EN: ch3 failing its min bound sets irq=1 at LATCH.
  - irq holds until irq_clr=1.
  - irq_clr coincident with a new failing LATCH leaves irq=1.
